// File: rtl/csi2_packet_transmitter_pkg.sv
// Shared CSI-2 definitions: data types, sync byte, header ECC and CRC-16 helpers.
// Used by both the packet transmitter and the camera receiver.
package csi2_pkg;

    localparam logic [5:0] DT_FS     = 6'h00;
    localparam logic [5:0] DT_FE     = 6'h01;
    localparam logic [5:0] DT_LS     = 6'h02;
    localparam logic [5:0] DT_LE     = 6'h03;
    localparam logic [5:0] DT_YUV422 = 6'h1E;
    localparam logic [5:0] DT_RAW8   = 6'h2A;

    localparam logic [7:0]  SYNC_BYTE     = 8'hB8;
    localparam logic [15:0] CRC_INIT      = 16'hFFFF;
    localparam logic [15:0] CRC_POLY_REFL = 16'h8408;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_HEADER,
        ST_PAYLOAD,
        ST_CRC,
        ST_GAP
    } tx_state_e;

    // Data types 0x00-0x0F are short packets (no payload, no footer).
    function automatic logic is_short(input logic [5:0] dt);
        return (dt <= 6'h0F);
    endfunction

    // 6-bit Hamming ECC over {WC, DI}; each parity bit covers a fixed set of data bits.
    function automatic logic [5:0] csi2_ecc(input logic [23:0] d);
        logic [5:0] p;
        p[0] = ^(d & 24'hF12CB7);
        p[1] = ^(d & 24'hF2555B);
        p[2] = ^(d & 24'h749A6D);
        p[3] = ^(d & 24'hB8E38E);
        p[4] = ^(d & 24'hDF03F0);
        p[5] = ^(d & 24'hEFFC00);
        return p;
    endfunction

    // One byte of the reflected CRC-16 (x^16+x^12+x^5+1), data consumed LSB first.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc ^ {8'h00, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/csi2_packet_transmitter_crc16_parallel.sv
// Combinational CRC-16 update over the first 0..NUM_LANES bytes of a beat.
// byte_mask selects which slots take part; slot 0 is folded in first.
module csi2_crc16_parallel
    import csi2_pkg::*;
#(
    parameter int NUM_LANES = 2
) (
    input  logic [15:0]            crc_in,
    input  logic [8*NUM_LANES-1:0] data,
    input  logic [NUM_LANES-1:0]   byte_mask,
    output logic [15:0]            crc_out
);

    // Fold each selected byte into the running CRC in slot order.
    always_comb begin
        crc_out = crc_in;
        for (int k = 0; k < NUM_LANES; k++) begin
            if (byte_mask[k]) begin
                crc_out = crc16_byte(crc_out, data[k*8 +: 8]);
            end
        end
    end

endmodule

// File: rtl/csi2_packet_transmitter.sv
// CSI-2 packet transmitter: sync, header with ECC, payload, CRC footer, spread
// round-robin across NUM_LANES byte lanes. Lane outputs are registered, so a beat
// decided in state X appears on the lanes one clock later.
// Handshake: a packet request is taken on a clock edge where start && tx_ready;
// a payload beat is taken on every edge where payload_ready is high, and the
// source must hold payload_valid high then (a low valid is logged as underflow).
module csi2_packet_transmitter
    import csi2_pkg::*;
#(
    parameter int NUM_LANES = 2,
    parameter int MIN_GAP   = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [1:0]             virtual_channel,
    input  logic [5:0]             data_type,
    input  logic [15:0]            word_count,
    output logic                   tx_ready,
    input  logic [8*NUM_LANES-1:0] payload_data,
    output logic                   payload_ready,
    input  logic                   payload_valid,
    output logic [8*NUM_LANES-1:0] lane_data,
    output logic [NUM_LANES-1:0]   lane_enable,
    output logic                   underflow,
    output logic                   busy
);

    localparam int HDR_BEATS = 4 / NUM_LANES;
    localparam int GAP_W     = $clog2(MIN_GAP + 2);

    tx_state_e              state;
    tx_state_e              next_state;
    logic [1:0]             vc_q;
    logic [5:0]             dt_q;
    logic [15:0]            wc_q;
    logic [15:0]            byte_cnt;
    logic [15:0]            crc_q;
    logic [15:0]            crc_next;
    logic [1:0]             crc_idx;
    logic [1:0]             hdr_beat;
    logic [GAP_W-1:0]       gap_cnt;
    logic                   accept;
    logic [7:0]             di;
    logic [31:0]            hdr_word;
    int                     take;
    int                     free_slots;
    logic                   last_beat;
    logic [8*NUM_LANES-1:0] pay_bytes;
    logic [NUM_LANES-1:0]   pay_mask;
    logic [8*NUM_LANES-1:0] lane_data_d;
    logic [NUM_LANES-1:0]   lane_enable_d;

    assign tx_ready      = (state == ST_IDLE) && (gap_cnt == '0);
    assign payload_ready = (state == ST_PAYLOAD);
    assign accept        = start && tx_ready;
    assign di            = {vc_q, dt_q};
    assign hdr_word      = {2'b00, csi2_ecc({wc_q, di}), wc_q[15:8], wc_q[7:0], di};

    // Payload beat sizing: bytes taken this beat, free slots left for the footer.
    always_comb begin
        take       = (int'(byte_cnt) < NUM_LANES) ? int'(byte_cnt) : NUM_LANES;
        free_slots = NUM_LANES - take;
        last_beat  = (int'(byte_cnt) <= NUM_LANES);
        pay_bytes  = payload_valid ? payload_data : '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            pay_mask[k] = (k < take);
        end
    end

    csi2_crc16_parallel #(.NUM_LANES(NUM_LANES)) u_crc (
        .crc_in    (crc_q),
        .data      (pay_bytes),
        .byte_mask (pay_mask),
        .crc_out   (crc_next)
    );

    // State register; reset aborts any packet in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= next_state;
    end

    // Next-state decode.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:    if (accept) next_state = ST_SYNC;
            ST_SYNC:    next_state = ST_HEADER;
            ST_HEADER: begin
                if (int'(hdr_beat) == HDR_BEATS - 1) begin
                    if (is_short(dt_q))      next_state = ST_GAP;
                    else if (wc_q == 16'd0)  next_state = ST_CRC;
                    else                     next_state = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: if (last_beat) next_state = (free_slots >= 2) ? ST_GAP : ST_CRC;
            ST_CRC:     if (int'(crc_idx) + NUM_LANES >= 2) next_state = ST_GAP;
            ST_GAP:     if (gap_cnt == '0) next_state = ST_IDLE;
            default:    next_state = ST_IDLE;
        endcase
    end

    // Lane contents for the beat produced by the current state.
    always_comb begin
        lane_data_d   = '0;
        lane_enable_d = '0;
        case (state)
            ST_SYNC: begin
                for (int k = 0; k < NUM_LANES; k++) lane_data_d[k*8 +: 8] = SYNC_BYTE;
                lane_enable_d = '1;
            end
            ST_HEADER: begin
                for (int k = 0; k < NUM_LANES; k++) begin
                    lane_data_d[k*8 +: 8] = hdr_word[(int'(hdr_beat) * NUM_LANES + k) * 8 +: 8];
                end
                lane_enable_d = '1;
            end
            ST_PAYLOAD: begin
                for (int k = 0; k < NUM_LANES; k++) begin
                    if (k < take) begin
                        lane_data_d[k*8 +: 8] = pay_bytes[k*8 +: 8];
                        lane_enable_d[k]      = 1'b1;
                    end else if (last_beat && (k - take) < 2) begin
                        lane_data_d[k*8 +: 8] = crc_next[(k - take) * 8 +: 8];
                        lane_enable_d[k]      = 1'b1;
                    end
                end
            end
            ST_CRC: begin
                for (int k = 0; k < NUM_LANES; k++) begin
                    if (int'(crc_idx) + k < 2) begin
                        lane_data_d[k*8 +: 8] = crc_q[(int'(crc_idx) + k) * 8 +: 8];
                        lane_enable_d[k]      = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // Registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lane_data   <= '0;
            lane_enable <= '0;
            busy        <= 1'b0;
        end else begin
            lane_data   <= lane_data_d;
            lane_enable <= lane_enable_d;
            busy        <= (next_state != ST_IDLE);
        end
    end

    // Packet fields, byte counter, running CRC and beat indices.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vc_q     <= '0;
            dt_q     <= '0;
            wc_q     <= '0;
            byte_cnt <= '0;
            crc_q    <= CRC_INIT;
            crc_idx  <= '0;
            hdr_beat <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        vc_q     <= virtual_channel;
                        dt_q     <= data_type;
                        wc_q     <= word_count;
                        byte_cnt <= word_count;
                        crc_q    <= CRC_INIT;
                        crc_idx  <= '0;
                        hdr_beat <= '0;
                    end
                end
                ST_HEADER: hdr_beat <= hdr_beat + 2'd1;
                ST_PAYLOAD: begin
                    byte_cnt <= byte_cnt - 16'(take);
                    crc_q    <= crc_next;
                    // Footer bytes already placed in the last payload beat.
                    if (last_beat) crc_idx <= 2'(free_slots);
                end
                ST_CRC: crc_idx <= crc_idx + 2'(NUM_LANES);
                default: ;
            endcase
        end
    end

    // Inter-packet gap counter; also holds off tx_ready after reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            gap_cnt <= GAP_W'(MIN_GAP);
        end else if (state != ST_GAP && next_state == ST_GAP) begin
            gap_cnt <= GAP_W'(MIN_GAP);
        end else if ((state == ST_GAP || state == ST_IDLE) && gap_cnt != '0) begin
            gap_cnt <= gap_cnt - GAP_W'(1);
        end
    end

    // Sticky underflow flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)                                underflow <= 1'b0;
        else if (payload_ready && !payload_valid) underflow <= 1'b1;
    end

endmodule

// File: tb/tb_csi2_packet_transmitter.sv
// Self-checking bench for csi2_packet_transmitter: directed cases plus random
// packets, compared beat by beat against a byte-stream reference model.
module tb_csi2_packet_transmitter;

    localparam int N       = 2;
    localparam int MIN_GAP = 4;

    logic           clock = 1'b0;
    logic           reset = 1'b0;
    logic           start = 1'b0;
    logic [1:0]     virtual_channel = '0;
    logic [5:0]     data_type = '0;
    logic [15:0]    word_count = '0;
    logic           tx_ready;
    logic [8*N-1:0] payload_data = '0;
    logic           payload_ready;
    logic           payload_valid = 1'b0;
    logic [8*N-1:0] lane_data;
    logic [N-1:0]   lane_enable;
    logic           underflow;
    logic           busy;

    int             n_vec = 0;
    int             n_err = 0;
    logic [7:0]     exp_q[$];
    logic [N-1:0]   got_en_q[$];
    logic [8*N-1:0] got_data_q[$];
    logic [7:0]     pay_mem [0:255];
    int             pb = 0;
    int             drop_beat = -1;
    int             idle_run = 0;
    int             last_gap = 0;
    logic           exp_uf = 1'b0;

    logic [1:0]     r_vc;
    logic [5:0]     r_dt;
    logic [15:0]    r_wc;
    int             r_drop;

    csi2_packet_transmitter #(.NUM_LANES(N), .MIN_GAP(MIN_GAP)) dut (
        .clock           (clock),
        .reset           (reset),
        .start           (start),
        .virtual_channel (virtual_channel),
        .data_type       (data_type),
        .word_count      (word_count),
        .tx_ready        (tx_ready),
        .payload_data    (payload_data),
        .payload_ready   (payload_ready),
        .payload_valid   (payload_valid),
        .lane_data       (lane_data),
        .lane_enable     (lane_enable),
        .underflow       (underflow),
        .busy            (busy)
    );

    // Clock.
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ECC model: every data bit contributes a fixed 6-bit code; XOR the codes of set bits.
    function automatic logic [5:0] model_ecc(input logic [23:0] d);
        logic [5:0] codes [24];
        logic [5:0] e;
        codes = '{6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19,
                  6'h1A, 6'h1C, 6'h23, 6'h25, 6'h26, 6'h29, 6'h2A, 6'h2C,
                  6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B};
        e = '0;
        for (int i = 0; i < 24; i++) if (d[i]) e = e ^ codes[i];
        return e;
    endfunction

    // Bit-serial reflected CRC-16 model, LSB of each byte first.
    function automatic logic [15:0] model_crc(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        logic        fb;
        r = c;
        for (int i = 0; i < 8; i++) begin
            fb = r[0] ^ b[i];
            r  = {1'b0, r[15:1]};
            if (fb) r = r ^ 16'h8408;
        end
        return r;
    endfunction

    // Lane monitor: records every enabled beat and the idle run before each packet.
    initial forever begin
        @(negedge clock);
        if (lane_enable !== '0) begin
            got_en_q.push_back(lane_enable);
            got_data_q.push_back(lane_data);
            if (idle_run > 0) last_gap = idle_run;
            idle_run = 0;
        end else begin
            idle_run++;
        end
    end

    // Payload source: presents the next beat whenever the DUT asks for one.
    initial forever begin
        @(negedge clock);
        if (payload_ready === 1'b1) begin
            if (pb == drop_beat) begin
                payload_valid = 1'b0;
                for (int k = 0; k < N; k++) payload_data[k*8 +: 8] = 8'($urandom_range(1, 255));
            end else begin
                payload_valid = 1'b1;
                for (int k = 0; k < N; k++) begin
                    payload_data[k*8 +: 8] = (pb * N + k < 256) ? pay_mem[pb * N + k] : 8'h00;
                end
            end
            pb++;
        end else begin
            payload_valid = 1'b0;
        end
    end

    task automatic check_reset_state();
        check("rst_lane_enable", 32'(lane_enable), 32'd0);
        check("rst_lane_data", 32'(lane_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_underflow", 32'(underflow), 32'd0);
        check("rst_payload_ready", 32'(payload_ready), 32'd0);
        check("rst_tx_ready", 32'(tx_ready), 32'd0);
    endtask

    // Releases reset at a falling edge; tx_ready must rise after exactly MIN_GAP edges.
    task automatic release_reset();
        reset = 1'b0;
        for (int i = 1; i <= MIN_GAP; i++) begin
            @(negedge clock);
            check("tx_ready_after_reset", 32'(tx_ready), 32'(i == MIN_GAP));
        end
    endtask

    task automatic send_packet(input logic [1:0] vc, input logic [5:0] dt, input logic [15:0] wc,
                               input int drop, input bit fill);
        logic [15:0]    crc;
        logic [7:0]     b;
        logic [7:0]     di;
        logic [N-1:0]   e_en;
        logic [8*N-1:0] e_data;
        int             len, nbeats, t, exp_pb, idx;
        bit             is_long;

        is_long = (dt > 6'h0F);
        if (is_long && fill) for (int i = 0; i < int'(wc); i++) pay_mem[i] = 8'($urandom);

        // Expected byte stream: sync, header, then payload and footer packed contiguously.
        exp_q.delete();
        for (int k = 0; k < N; k++) exp_q.push_back(8'hB8);
        di = {vc, dt};
        exp_q.push_back(di);
        exp_q.push_back(wc[7:0]);
        exp_q.push_back(wc[15:8]);
        exp_q.push_back({2'b00, model_ecc({wc, di})});
        exp_pb = 0;
        if (is_long) begin
            crc = 16'hFFFF;
            for (int i = 0; i < int'(wc); i++) begin
                b = (i / N == drop) ? 8'h00 : pay_mem[i];
                exp_q.push_back(b);
                crc = model_crc(crc, b);
            end
            exp_q.push_back(crc[7:0]);
            exp_q.push_back(crc[15:8]);
            exp_pb = (int'(wc) + N - 1) / N;
            if (drop >= 0 && drop < exp_pb) exp_uf = 1'b1;
        end

        t = 0;
        while (tx_ready !== 1'b1 && t < 200) begin
            @(negedge clock);
            t++;
        end
        check("tx_ready_wait", 32'(tx_ready), 32'd1);

        got_en_q.delete();
        got_data_q.delete();
        pb = 0;
        drop_beat = drop;
        virtual_channel = vc;
        data_type = dt;
        word_count = wc;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;

        // Run to completion; a stray request mid-packet must be dropped.
        t = 0;
        while (busy === 1'b1 && t < 1000) begin
            @(negedge clock);
            t++;
            if (t == 2) begin
                start = 1'b1;
                virtual_channel = 2'($urandom);
                data_type = 6'($urandom);
                word_count = 16'($urandom_range(0, 40));
            end
            if (t == 3) start = 1'b0;
        end
        start = 1'b0;
        check("busy_timeout", 32'(t < 1000), 32'd1);
        repeat (4) @(negedge clock);

        len = exp_q.size();
        nbeats = (len + N - 1) / N;
        check("beat_count", 32'(got_en_q.size()), 32'(nbeats));
        for (int i = 0; i < nbeats && i < got_en_q.size(); i++) begin
            e_en = '0;
            e_data = '0;
            for (int k = 0; k < N; k++) begin
                idx = i * N + k;
                if (idx < len) begin
                    e_en[k] = 1'b1;
                    e_data[k*8 +: 8] = exp_q[idx];
                end
            end
            check("lane_enable", 32'(got_en_q[i]), 32'(e_en));
            check("lane_data", 32'(got_data_q[i]), 32'(e_data));
        end
        check("payload_beats", 32'(pb), 32'(exp_pb));
        check("underflow", 32'(underflow), 32'(exp_uf));
        check("min_gap", 32'(last_gap >= MIN_GAP), 32'd1);
    endtask

    // Reset asserted in the middle of a payload: lanes drop at once, no resumption.
    task automatic reset_mid_packet();
        int t;
        for (int i = 0; i < 30; i++) pay_mem[i] = 8'($urandom);
        t = 0;
        while (tx_ready !== 1'b1 && t < 200) begin
            @(negedge clock);
            t++;
        end
        pb = 0;
        drop_beat = -1;
        virtual_channel = 2'd0;
        data_type = 6'h2A;
        word_count = 16'd30;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        t = 0;
        while (pb < 4 && t < 200) begin
            @(negedge clock);
            t++;
        end
        check("payload_reached", 32'(pb >= 4), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("abort_lane_enable", 32'(lane_enable), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_payload_ready", 32'(payload_ready), 32'd0);
        check("abort_tx_ready", 32'(tx_ready), 32'd0);
        exp_uf = 1'b0;
        @(negedge clock);
        check("abort_underflow", 32'(underflow), 32'd0);
        release_reset();
    endtask

    initial begin
        #1 reset = 1'b1;
        repeat (3) @(negedge clock);
        check_reset_state();
        release_reset();

        // Frame start short packet: all-zero header, zero ECC.
        send_packet(2'd0, 6'h00, 16'h0000, -1, 1'b1);
        // Short packet carrying a data field.
        send_packet(2'd1, 6'h08, 16'hFACE, -1, 1'b1);
        // Long packet with a fixed 8-byte payload.
        pay_mem[0] = 8'hAD; pay_mem[1] = 8'hDE; pay_mem[2] = 8'hE1; pay_mem[3] = 8'hFE;
        pay_mem[4] = 8'h5E; pay_mem[5] = 8'hEA; pay_mem[6] = 8'h15; pay_mem[7] = 8'h0D;
        send_packet(2'd0, 6'h18, 16'd8, -1, 1'b0);
        // Odd length: footer split across the last payload beat and a partial beat.
        send_packet(2'd0, 6'h2A, 16'd3, -1, 1'b1);
        // Empty long packet: footer straight after the header.
        send_packet(2'd3, 6'h2A, 16'd0, -1, 1'b1);
        // Payload source misses one beat mid-packet.
        send_packet(2'd2, 6'h1E, 16'd10, 2, 1'b1);

        reset_mid_packet();
        send_packet(2'd1, 6'h2A, 16'd5, -1, 1'b1);

        repeat (14) begin
            r_vc = 2'($urandom);
            r_dt = 6'($urandom);
            if ($urandom_range(0, 1) == 0) r_dt[5:4] = 2'b00;
            else if (r_dt <= 6'h0F) r_dt[4] = 1'b1;
            if (r_dt <= 6'h0F) begin
                r_wc = 16'($urandom);
                r_drop = -1;
            end else begin
                r_wc = 16'($urandom_range(0, 40));
                r_drop = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, (int'(r_wc) + N - 1) / N)) : -1;
            end
            send_packet(r_vc, r_dt, r_wc, r_drop, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
